// File: rtl/bcd_scan_counter_if.sv
// Control and display bus of the BCD scan counter: count controls in, scanned digit out.
// The master drives en/up/clear; the slave (the counter) drives the display-side signals.
interface bcd_scan_counter_if;
    logic        en;
    logic        up;
    logic        clear;
    logic [3:0]  bcd;
    logic [3:0]  digit_sel;
    logic [15:0] count_val;
    logic        wrap;

    modport master (
        output en, up, clear,
        input  bcd, digit_sel, count_val, wrap
    );

    modport slave (
        input  en, up, clear,
        output bcd, digit_sel, count_val, wrap
    );
endinterface

// File: rtl/bcd_scan_counter.sv
// 4-digit BCD up/down counter with a free-running digit scanner for a multiplexed display.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading-zero digits via digit_sel.
module bcd_scan_counter #(
    parameter int unsigned CLK_DIV  = 50_000_000,
    parameter int unsigned SCAN_DIV = 50_000
) (
    input  logic               clk,
    input  logic               rst,
    bcd_scan_counter_if.slave  cnt_io
);

    localparam int CNT_W  = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    // Index 3 is the most significant digit, so the packed value is {d3,d2,d1,d0}.
    typedef logic [3:0][3:0] digits_t;

    typedef struct packed {
        digits_t digits;
        logic    wrap;
    } step_t;

    // One BCD count step; the carry/borrow surviving past d3 is the wrap.
    function automatic step_t bcd_step(input digits_t cur, input logic count_up);
        step_t res;
        logic  carry;
        res.digits = cur;
        res.wrap   = 1'b0;
        carry      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (count_up) begin
                    if (cur[i] >= 4'd9) begin
                        res.digits[i] = 4'd0;
                    end else begin
                        res.digits[i] = cur[i] + 4'd1;
                        carry         = 1'b0;
                    end
                end else begin
                    if (cur[i] == 4'd0) begin
                        res.digits[i] = 4'd9;
                    end else begin
                        res.digits[i] = cur[i] - 4'd1;
                        carry         = 1'b0;
                    end
                end
            end
        end
        res.wrap = carry;
        return res;
    endfunction

    logic [CNT_W-1:0]  cnt_pre_q, cnt_pre_d;
    logic [SCAN_W-1:0] scan_pre_q, scan_pre_d;
    logic [1:0]        scan_idx_q, scan_idx_d;
    digits_t           digits_q, digits_d;
    logic              wrap_q, wrap_d;

    logic              tick;
    logic              scan_last;
    step_t             nxt;

    assign tick      = (cnt_pre_q == CNT_LAST) && cnt_io.en;
    assign scan_last = (scan_pre_q == SCAN_LAST);
    assign nxt       = bcd_step(digits_q, cnt_io.up);

    // Count path: clear beats a simultaneous tick; the prescaler only moves while enabled.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise
        // any path that skips an assignment infers a latch.
        cnt_pre_d = cnt_pre_q;
        digits_d  = digits_q;
        wrap_d    = 1'b0;
        if (cnt_io.clear) begin
            cnt_pre_d = '0;
            digits_d  = '0;
        end else if (cnt_io.en) begin
            if (tick) begin
                cnt_pre_d = '0;
                digits_d  = nxt.digits;
                wrap_d    = nxt.wrap;
            end else begin
                cnt_pre_d = cnt_pre_q + CNT_W'(1);
            end
        end
    end

    // Scan path: free-running, untouched by en, up or clear.
    always_comb begin
        scan_pre_d = scan_pre_q + SCAN_W'(1);
        scan_idx_d = scan_idx_q;
        if (scan_last) begin
            scan_pre_d = '0;
            scan_idx_d = scan_idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // the pre-edge values, independent of statement order.
        if (rst) begin
            cnt_pre_q  <= '0;
            scan_pre_q <= '0;
            scan_idx_q <= 2'd0;
            digits_q   <= '0;
            wrap_q     <= 1'b0;
        end else begin
            cnt_pre_q  <= cnt_pre_d;
            scan_pre_q <= scan_pre_d;
            scan_idx_q <= scan_idx_d;
            digits_q   <= digits_d;
            wrap_q     <= wrap_d;
        end
    end

    logic [3:0] sel_onehot;
    logic [3:0] blank;

    assign sel_onehot = 4'b0001 << scan_idx_q;

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more-significant digit are zero.
    always_comb begin
        blank    = 4'b0000;
        blank[3] = (digits_q[3] == 4'd0);
        blank[2] = blank[3] && (digits_q[2] == 4'd0);
        blank[1] = blank[2] && (digits_q[1] == 4'd0);
        blank[0] = 1'b0;
    end
`else
    assign blank = 4'b0000;
`endif

    assign cnt_io.bcd       = digits_q[scan_idx_q];
    assign cnt_io.digit_sel = blank[scan_idx_q] ? 4'b0000 : sel_onehot;
    assign cnt_io.count_val = digits_q;
    assign cnt_io.wrap      = wrap_q;

endmodule
